// File: rtl/llc_mem_responder_if.sv
// llc_mem_responder_if: LLC <-> backing-memory line channel.
// The LLC (or a bench) drives through the master modport; the memory
// responder sits on the slave modport.
interface llc_mem_responder_if #(
  parameter int LINE_BITS      = 128,
  parameter int LINE_ADDR_BITS = 28
);
  // request channel
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_hwrite;
  logic [2:0]                mem_req_hsize;
  logic [1:0]                mem_req_hprot;
  logic [LINE_ADDR_BITS-1:0] mem_req_addr;
  logic [LINE_BITS-1:0]      mem_req_line;
  // read response channel
  logic                      mem_rsp_valid;
  logic                      mem_rsp_ready;
  logic [LINE_BITS-1:0]      mem_rsp_line;
  // sticky range error
  logic                      mem_err;

  modport master (
    output mem_req_valid, mem_req_hwrite, mem_req_hsize, mem_req_hprot,
           mem_req_addr, mem_req_line, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_line, mem_err
  );

  modport slave (
    input  mem_req_valid, mem_req_hwrite, mem_req_hsize, mem_req_hprot,
           mem_req_addr, mem_req_line, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_line, mem_err
  );
endinterface

// File: rtl/llc_mem_responder.sv
// llc_mem_responder: single-outstanding, fixed-latency, line-granular memory
// behind the LLC. Reads return the stored line, or zero for a line that has
// never been written since reset. Writes produce no response.
// Optional feature macro: LLC_MEM_RANGE_CHECK_EN -- flags any address with
// nonzero bits above DEPTH_LOG2 (sticky mem_err), drops such writes and
// answers such reads with all-ones. Without it, high address bits alias.
module llc_mem_responder #(
  parameter int LINE_BITS      = 128,
  parameter int LINE_ADDR_BITS = 28,
  parameter int DEPTH_LOG2     = 8,
  parameter int LATENCY        = 4   // 1..15
) (
  input  logic                clk,
  input  logic                rst,
  llc_mem_responder_if.slave  mem
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  // With LATENCY==1 the access completes on the accept edge itself.
  localparam bit DIRECT = (LATENCY == 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [LINE_BITS-1:0]  line_t;
  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        req_ready, rsp_valid;

  // latched request
  logic        wr_q;
  idx_t        idx_q;
  line_t       wdata_q;
  logic        oor_q;

  // storage
  line_t       mem_arr [DEPTH];
  logic [DEPTH-1:0] vld;
  line_t       rsp_line_q;

  logic        accept, oor_in, complete;
  logic        cmp_write, cmp_oor;
  idx_t        cmp_idx;
  line_t       cmp_line;
  logic        unused_fields;

  assign accept = mem.mem_req_valid && (state == IDLE);

`ifdef LLC_MEM_RANGE_CHECK_EN
  logic err_q;
  assign oor_in        = |mem.mem_req_addr[LINE_ADDR_BITS-1:DEPTH_LOG2];
  assign mem.mem_err   = err_q;
  assign unused_fields = ^{mem.mem_req_hsize, mem.mem_req_hprot};

  // sticky range error, set on the accept of an out-of-range request
  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (accept && oor_in) err_q <= 1'b1;
  end
`else
  assign oor_in        = 1'b0;
  assign mem.mem_err   = 1'b0;
  assign unused_fields = ^{mem.mem_req_hsize, mem.mem_req_hprot,
                           mem.mem_req_addr[LINE_ADDR_BITS-1:DEPTH_LOG2]};
`endif

  // The counter holds the cycles still to spend in WAIT including the current
  // one; the access completes on the edge that would take it to zero, which
  // puts the write commit at T+LATENCY-1 and the first response cycle at
  // T+LATENCY for an accept ending cycle T.
  assign complete  = DIRECT ? accept : ((state == WAIT) && (cnt == 4'd1));
  assign cmp_write = DIRECT ? mem.mem_req_hwrite                  : wr_q;
  assign cmp_idx   = DIRECT ? mem.mem_req_addr[DEPTH_LOG2-1:0]    : idx_q;
  assign cmp_line  = DIRECT ? mem.mem_req_line                    : wdata_q;
  assign cmp_oor   = DIRECT ? oor_in                              : oor_q;

  // state register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state and handshake outputs
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (complete) state_next = cmp_write ? IDLE : RSP;
          else          state_next = WAIT;
        end
      end
      WAIT: begin
        if (complete) state_next = cmp_write ? IDLE : RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (mem.mem_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_req_ready = req_ready;
  assign mem.mem_rsp_valid = rsp_valid;
  assign mem.mem_rsp_line  = rsp_valid ? rsp_line_q : '0;

  // latency counter: loaded at accept, counts down in WAIT, never wraps
  always_ff @(posedge clk) begin
    if (rst)                              cnt <= 4'd0;
    else if (accept)                      cnt <= 4'(LATENCY - 1);
    else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // request capture; only meaningful after an accept, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= mem.mem_req_hwrite;
      idx_q   <= mem.mem_req_addr[DEPTH_LOG2-1:0];
      wdata_q <= mem.mem_req_line;
      oor_q   <= oor_in;
    end
  end

  // per-line valid bits, set on the same edge the line is stored
  always_ff @(posedge clk) begin
    if (rst)                                    vld <= '0;
    else if (complete && cmp_write && !cmp_oor) vld[cmp_idx] <= 1'b1;
  end

  // line storage
  // NOTE: the array has no reset; the valid bits above mask stale contents.
  always_ff @(posedge clk) begin
    if (complete && cmp_write && !cmp_oor) mem_arr[cmp_idx] <= cmp_line;
  end

  // read data sampled when the access completes, held through RSP
  always_ff @(posedge clk) begin
    if (rst)
      rsp_line_q <= '0;
    else if (complete && !cmp_write)
      rsp_line_q <= cmp_oor ? '1 : (vld[cmp_idx] ? mem_arr[cmp_idx] : '0);
  end

endmodule
